// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the instruction-RAM loader and the CPU/RAM top.
package prog_loader_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    LEN,
    HI,
    LO,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 16-bit words, writes them to the
// instruction RAM from start_pc, then releases the CPU once the checksum matches.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  loader_state_t     state_q, state_nxt;
  logic [BYTE_W-1:0] n_q, n_nxt;
  logic [BYTE_W-1:0] idx_q, idx_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [BYTE_W-1:0] hi_q, hi_nxt;
  logic [BYTE_W-1:0] lo_q, lo_nxt;
  logic [BYTE_W-1:0] acc_q, acc_nxt;

  logic              in_ready_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic              ram_w_en_nxt;
  logic [DATA_W-1:0] ram_w_data_nxt;
  logic              cpu_rst_n_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic              accept;

  // Next-state, datapath and output decode; outputs are registered from the next state
  always_comb begin
    state_nxt = state_q;
    n_nxt     = n_q;
    idx_nxt   = idx_q;
    addr_nxt  = addr_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    acc_nxt   = acc_q;
    accept    = in_valid && in_ready;

    case (state_q)
      LEN: begin
        if (accept) begin
          n_nxt     = in_byte;
          addr_nxt  = start_pc;
          idx_nxt   = '0;
          acc_nxt   = '0;
          state_nxt = (in_byte == '0) ? ERR : HI;
        end
      end
      HI: begin
        if (accept) begin
          hi_nxt    = in_byte;
          acc_nxt   = acc_q ^ in_byte;
          state_nxt = LO;
        end
      end
      LO: begin
        if (accept) begin
          lo_nxt    = in_byte;
          acc_nxt   = acc_q ^ in_byte;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        addr_nxt  = ADDR_W'(addr_q + ADDR_W'(1));
        idx_nxt   = BYTE_W'(idx_q + BYTE_W'(1));
        state_nxt = (BYTE_W'(idx_q + BYTE_W'(1)) == n_q) ? CSUM : HI;
      end
      CSUM: begin
        if (accept) begin
          state_nxt = (in_byte == acc_q) ? DONE : ERR;
        end
      end
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = LEN;
    endcase

    in_ready_nxt   = (state_nxt == LEN) || (state_nxt == HI) ||
                     (state_nxt == LO)  || (state_nxt == CSUM);
    ram_w_en_nxt   = (state_nxt == WRITE);
    ram_addr_nxt   = ram_w_en_nxt ? addr_nxt : '0;
    ram_w_data_nxt = ram_w_en_nxt ? DATA_W'({hi_nxt, lo_nxt}) : '0;
    done_nxt       = (state_nxt == DONE);
    err_nxt        = (state_nxt == ERR);
    cpu_rst_n_nxt  = (state_nxt == DONE);
  end

  // State, datapath and output registers; RAM contents are untouched by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LEN;
      n_q        <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      in_ready   <= 1'b0;
      ram_addr   <= '0;
      ram_w_en   <= 1'b0;
      ram_w_data <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      n_q        <= n_nxt;
      idx_q      <= idx_nxt;
      addr_q     <= addr_nxt;
      hi_q       <= hi_nxt;
      lo_q       <= lo_nxt;
      acc_q      <= acc_nxt;
      in_ready   <= in_ready_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_w_en   <= ram_w_en_nxt;
      ram_w_data <= ram_w_data_nxt;
      cpu_rst_n  <= cpu_rst_n_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: stream-level reference model plus directed
// and randomized loads.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] start_pc;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_w_en;
  logic [DATA_W-1:0] ram_w_data;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start_pc  (start_pc),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .ram_addr  (ram_addr),
    .ram_w_en  (ram_w_en),
    .ram_w_data(ram_w_data),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: interprets accepted bytes by their position in the stream
  bit          started   = 1'b0;
  bit          post_reset;
  bit          write_due;
  int          cnt;
  int          n_words;
  int          status;          // 0 running, 1 done, 2 error
  logic [7:0]  pc, hi_b, acc;
  logic [7:0]  exp_addr;
  logic [15:0] exp_data;
  logic [15:0] exp_ram [256];
  logic [15:0] dut_ram [256];
  logic [23:0] wlog [$];

  always @(posedge clk) begin
    if (rst) begin
      started    = 1'b1;
      post_reset = 1'b1;
      write_due  = 1'b0;
      cnt        = 0;
      status     = 0;
    end else begin
      post_reset = 1'b0;
      write_due  = 1'b0;
      if (started && in_valid && in_ready === 1'b1 && status == 0) begin
        if (cnt == 0) begin
          n_words = int'(in_byte);
          pc      = start_pc;
          acc     = 8'h00;
          if (in_byte == 8'h00) status = 2;
        end else if (cnt <= 2 * n_words) begin
          acc = acc ^ in_byte;
          if (cnt % 2 == 1) hi_b = in_byte;
          else begin
            write_due         = 1'b1;
            exp_addr          = 8'(int'(pc) + cnt / 2 - 1);
            exp_data          = {hi_b, in_byte};
            exp_ram[exp_addr] = exp_data;
          end
        end else begin
          status = (in_byte == acc) ? 1 : 2;
        end
        cnt++;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(!post_reset && !write_due && status == 0));
      chk("ram_w_en", 32'(ram_w_en), 32'(write_due));
      if (write_due) begin
        chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        chk("ram_w_data", 32'(ram_w_data), 32'(exp_data));
      end
      if (post_reset) begin
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_data", 32'(ram_w_data), 32'h0);
      end
      chk("done", 32'(done), 32'(status == 1));
      chk("err", 32'(err), 32'(status == 2));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(status == 1));
      if (ram_w_en === 1'b1) begin
        dut_ram[ram_addr] = ram_w_data;
        wlog.push_back({ram_addr, ram_w_data});
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one byte until it is accepted; optional random idle gaps first
  task automatic send(input logic [7:0] b, input bit rnd);
    bit took;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    took     = 1'b0;
    for (int g = 0; g < 50; g++) begin
      took = (in_ready === 1'b1);
      @(negedge clk);
      if (took) break;
    end
    if (!took) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic send_stream(input logic [7:0] bs[$], input bit rnd);
    foreach (bs[i]) send(bs[i], rnd);
    in_valid = 1'b0;
  endtask

  task automatic wait_term();
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || err === 1'b1) break;
      @(negedge clk);
    end
    chk("terminal_reached", 32'(done | err), 32'h1);
  endtask

  initial begin
    logic [7:0] s[$];
    int         base;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      exp_ram[i] = 16'h0;
      dut_ram[i] = 16'h0;
    end
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; start_pc = 8'h00;

    // Reset behaviour and first cycle after reset
    do_reset(2);
    chk("lit_rst_ready", 32'(in_ready), 32'h0);
    chk("lit_rst_cpu", 32'(cpu_rst_n), 32'h0);
    @(negedge clk);
    chk("lit_len_ready", 32'(in_ready), 32'h1);

    // Test 1: single word, good checksum
    base = wlog.size();
    s = '{8'h01, 8'hD2, 8'h05, 8'hD7};
    send_stream(s, 1'b0);
    wait_term();
    chk("t1_writes", 32'(wlog.size() - base), 32'd1);
    chk("t1_word", 32'(wlog[base]), 32'h00D205);
    chk("t1_done", 32'({done, cpu_rst_n, err}), 32'b110);

    // Test 2: bad checksum, error held
    do_reset(2);
    base = wlog.size();
    s = '{8'h01, 8'hD2, 8'h05, 8'h00};
    send_stream(s, 1'b0);
    repeat (20) @(negedge clk);
    chk("t2_word", 32'(wlog[base]), 32'h00D205);
    chk("t2_err", 32'({done, cpu_rst_n, err}), 32'b001);

    // Test 3: zero length
    do_reset(1);
    base = wlog.size();
    s = '{8'h00};
    send_stream(s, 1'b0);
    chk("t3_err_next", 32'(err), 32'h1);
    repeat (3) @(negedge clk);
    chk("t3_ready_low", 32'(in_ready), 32'h0);
    chk("t3_no_write", 32'(wlog.size() - base), 32'd0);

    // Test 4: address wrap FE->FF->00
    do_reset(1);
    start_pc = 8'hFE;
    base = wlog.size();
    s = '{8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h00};
    send_stream(s, 1'b0);
    wait_term();
    chk("t4_writes", 32'(wlog.size() - base), 32'd3);
    chk("t4_w0", 32'(wlog[base]),     32'hFE1111);
    chk("t4_w1", 32'(wlog[base + 1]), 32'hFF2222);
    chk("t4_w2", 32'(wlog[base + 2]), 32'h003333);
    chk("t4_done", 32'(done), 32'h1);

    // Test 5: test 1 with random valid gaps
    do_reset(1);
    start_pc = 8'h00;
    dut_ram[0] = 16'h0;
    s = '{8'h01, 8'hD2, 8'h05, 8'hD7};
    send_stream(s, 1'b1);
    wait_term();
    chk("t5_ram0", 32'(dut_ram[0]), 32'hD205);
    chk("t5_done", 32'(done), 32'h1);

    // Test 6: reset right after the first write of test 4, then test 1
    do_reset(1);
    start_pc = 8'hFE;
    dut_ram[8'hFE] = 16'h0;
    s = '{8'h03, 8'h11, 8'h11};
    send_stream(s, 1'b0);
    chk("t6_in_write", 32'(ram_w_en), 32'h1);
    @(negedge clk);
    do_reset(1);
    chk("t6_rst_outs", 32'({in_ready, ram_w_en, done, err, cpu_rst_n}), 32'h0);
    start_pc = 8'h00;
    s = '{8'h01, 8'hD2, 8'h05, 8'hD7};
    send_stream(s, 1'b0);
    wait_term();
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_ram_fe", 32'(dut_ram[8'hFE]), 32'h1111);
    chk("t6_ram_00", 32'(dut_ram[0]), 32'hD205);

    // Randomized loads; start_pc is scrambled after the length byte
    for (int l = 0; l < 8; l++) begin
      int nw;
      do_reset($urandom_range(1, 3));
      start_pc = 8'($urandom);
      nw = (l == 7) ? 255 : $urandom_range(1, 8);
      if (l == 7) start_pc = 8'h80;
      a = 8'h00;
      send(8'(nw), (l != 7));
      start_pc = 8'($urandom);
      s = {};
      for (int k = 0; k < 2 * nw; k++) begin
        s.push_back(8'($urandom));
        a = a ^ s[k];
      end
      if ($urandom_range(0, 2) == 0) a = a ^ 8'($urandom_range(1, 255));
      s.push_back(a);
      send_stream(s, (l != 7));
      wait_term();
    end

    for (int i = 0; i < 256; i++) chk("ram_image", 32'(dut_ram[i]), 32'(exp_ram[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
